// File: rtl/mbu_ctxstack.sv
// Memory Bank Unit with per-context bank registers, a context register and a
// LIFO context stack for interrupt entry/exit; drives AEXT and serves IBus reads.
module mbu_ctxstack #(
  parameter int DW          = 8,
  parameter int NBANK       = 8,
  parameter int NCTX        = 256,
  parameter int STACK_DEPTH = 4,
  parameter int IBW         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               raddr,
  input  logic [4:0]               waddr,
  input  logic [IBW-1:0]           ibus_in,
  output logic [IBW-1:0]           ibus_out,
  output logic                     ibus_oe,
  input  logic [$clog2(NBANK)-1:0] ir,
  input  logic                     ir_idx,
  input  logic                     fpram_rom,
  input  logic                     ctx_push,
  input  logic                     ctx_pop,
  output logic [DW-1:0]            aext,
  output logic                     war,
  output logic                     en,
  output logic                     stk_err
);

  localparam int IDXW = $clog2(NBANK);
  localparam int CTXW = $clog2(NCTX);
  localparam int SPW  = $clog2(STACK_DEPTH + 1);
  localparam logic [IDXW-1:0] BANK0 = '0;

  logic            r_mbn, r_mbp, r_ctx, w_mbn, w_mbp, w_ctx;
  logic [DW-1:0]   dflt;
  logic [IDXW-1:0] sel;
  logic [DW-1:0]   mb_q [NCTX][NBANK];
  logic [CTXW-1:0] ctx_q, ctx_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [CTXW-1:0] stack_q [STACK_DEPTH];
  logic [CTXW-1:0] stack_d [STACK_DEPTH];
  logic            en_q, en_d;
  logic            idx_armed_q, idx_armed_d;
  logic            stk_err_q, stk_err_d;
  logic            unused_ibus;

  assign r_mbn = (raddr == 5'b11011);
  assign r_mbp = (raddr == 5'b11100);
  assign r_ctx = (raddr == 5'b11101) || (raddr == 5'b11110);
  assign w_mbn = (waddr == 5'b11011);
  assign w_mbp = (waddr == 5'b11100);
  assign w_ctx = (waddr == 5'b11101) || (waddr == 5'b11110);
  assign war   = (waddr[4:2] == 3'b001);

  assign dflt        = {fpram_rom, {(DW-1){1'b0}}};
  assign sel         = idx_armed_q ? ir : IDXW'(waddr[1:0]);
  assign aext        = (war && en_q) ? mb_q[ctx_q][sel] : dflt;
  assign en          = en_q;
  assign stk_err     = stk_err_q;
  assign unused_ibus = ^ibus_in;

  // Until the first MBn write the banks are meaningless, so MBn/MBp reads show the panel default.
  always_comb begin
    ibus_oe  = r_mbn | r_mbp | r_ctx;
    ibus_out = '0;
    if (r_mbn)
      ibus_out = IBW'(en_q ? mb_q[ctx_q][ir] : dflt);
    else if (r_mbp)
      ibus_out = IBW'(en_q ? mb_q[ctx_q][BANK0] : dflt);
    else if (r_ctx)
      ibus_out = IBW'(ctx_q);
  end

  always_comb begin
    ctx_d       = ctx_q;
    sp_d        = sp_q;
    stack_d     = stack_q;
    stk_err_d   = stk_err_q;
    en_d        = en_q | w_mbn;
    idx_armed_d = ir_idx | (idx_armed_q & ~war);
    // Stack operations take priority over a CTX write on the same edge.
    if (ctx_push && ctx_pop) begin
      stk_err_d = 1'b1;
    end else if (ctx_push) begin
      ctx_d = '0;
      if (sp_q == SPW'(STACK_DEPTH)) begin
        stk_err_d = 1'b1;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++)
          if (sp_q == SPW'(i)) stack_d[i] = ctx_q;
        sp_d = sp_q + 1'b1;
      end
    end else if (ctx_pop) begin
      if (sp_q == '0) begin
        stk_err_d = 1'b1;
      end else begin
        sp_d = sp_q - 1'b1;
        for (int i = 0; i < STACK_DEPTH; i++)
          if (sp_q == SPW'(i + 1)) ctx_d = stack_q[i];
      end
    end else if (w_ctx) begin
      ctx_d = ibus_in[CTXW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx_q       <= '0;
      sp_q        <= '0;
      en_q        <= 1'b0;
      idx_armed_q <= 1'b0;
      stk_err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ctx_q       <= ctx_d;
      sp_q        <= sp_d;
      en_q        <= en_d;
      idx_armed_q <= idx_armed_d;
      stk_err_q   <= stk_err_d;
      stack_q     <= stack_d;
    end
  end

  // Bank file keeps its contents across reset; writes use the pre-edge context.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_mbn)
        mb_q[ctx_q][ir] <= ibus_in[DW-1:0];
      else if (w_mbp)
        mb_q[ctx_q][BANK0] <= ibus_in[DW-1:0];
    end
  end

endmodule

// File: tb/tb_mbu_ctxstack.sv
// Self-checking bench for mbu_ctxstack: a queue/associative-array model checked
// every cycle, plus directed literal checks that walk the main scenarios.
module tb_mbu_ctxstack;

  localparam int DW = 8, NBANK = 8, NCTX = 256, DEPTH = 4, IBW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [4:0]     raddr, waddr;
  logic [IBW-1:0] ibus_in;
  logic [2:0]     ir;
  logic           ir_idx, fpram_rom, ctx_push, ctx_pop;
  logic [IBW-1:0] ibus_out;
  logic           ibus_oe, war, en, stk_err;
  logic [DW-1:0]  aext;

  int vectors = 0;
  int miscompares = 0;

  int m_mb [int];
  int m_ctx = 0;
  bit m_en = 0, m_armed = 0, m_err = 0;
  int m_stack [$];

  mbu_ctxstack #(.DW(DW), .NBANK(NBANK), .NCTX(NCTX), .STACK_DEPTH(DEPTH), .IBW(IBW)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .waddr(waddr), .ibus_in(ibus_in),
    .ibus_out(ibus_out), .ibus_oe(ibus_oe), .ir(ir), .ir_idx(ir_idx),
    .fpram_rom(fpram_rom), .ctx_push(ctx_push), .ctx_pop(ctx_pop),
    .aext(aext), .war(war), .en(en), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after a rising edge, then wait to mid-cycle.
  task automatic applyStimulus(input logic [4:0] ra, input logic [4:0] wa, input logic [15:0] d,
                               input logic [2:0] irv, input bit idx, input bit push, input bit pop);
    @(posedge clk);
    #1;
    raddr = ra; waddr = wa; ibus_in = d; ir = irv;
    ir_idx = idx; ctx_push = push; ctx_pop = pop;
    @(negedge clk);
  endtask

  task automatic readCtx(input logic [15:0] exp, input string name);
    applyStimulus(5'b11101, 5'b00000, 16'h0, 3'd0, 0, 0, 0);
    checkOutput(name, ibus_out, exp);
  endtask

  // Reference model: bank file keyed by ctx*NBANK+bank, stack as a queue.
  always @(posedge clk or posedge rst) begin
    bit wr_ar;
    if (rst) begin
      m_ctx = 0; m_en = 0; m_armed = 0; m_err = 0;
      m_stack.delete();
    end else begin
      wr_ar = (waddr[4:2] == 3'b001);
      if (waddr == 5'b11011) begin
        m_mb[m_ctx * NBANK + int'(ir)] = int'(ibus_in[7:0]);
        m_en = 1;
      end
      if (waddr == 5'b11100) m_mb[m_ctx * NBANK] = int'(ibus_in[7:0]);
      if (ir_idx) m_armed = 1;
      else if (wr_ar) m_armed = 0;
      if (ctx_push && ctx_pop) begin
        m_err = 1;
      end else if (ctx_push) begin
        if (m_stack.size() == DEPTH) m_err = 1;
        else m_stack.push_back(m_ctx);
        m_ctx = 0;
      end else if (ctx_pop) begin
        if (m_stack.size() == 0) m_err = 1;
        else m_ctx = m_stack.pop_back();
      end else if (waddr == 5'b11101 || waddr == 5'b11110) begin
        m_ctx = int'(ibus_in[7:0]);
      end
    end
  end

  // Every mid-cycle, compare all outputs against the model where they are defined.
  always @(negedge clk) begin
    int key;
    int dflt;
    dflt = fpram_rom ? 32'h80 : 32'h0;
    checkOutput("war", war, waddr[4:2] == 3'b001);
    checkOutput("en", en, m_en);
    checkOutput("stk_err", stk_err, m_err);
    checkOutput("ibus_oe", ibus_oe, raddr inside {5'b11011, 5'b11100, 5'b11101, 5'b11110});
    if (waddr[4:2] == 3'b001 && m_en) begin
      key = m_ctx * NBANK + (m_armed ? int'(ir) : int'(waddr[1:0]));
      if (m_mb.exists(key)) checkOutput("aext", aext, m_mb[key]);
    end else begin
      checkOutput("aext_dflt", aext, dflt);
    end
    if (raddr == 5'b11011 || raddr == 5'b11100) begin
      key = m_ctx * NBANK + ((raddr == 5'b11011) ? int'(ir) : 0);
      if (!m_en) checkOutput("ibus_dflt", ibus_out, dflt);
      else if (m_mb.exists(key)) checkOutput("ibus_mb", ibus_out, m_mb[key]);
    end else if (raddr == 5'b11101 || raddr == 5'b11110) begin
      checkOutput("ibus_ctx", ibus_out, m_ctx);
    end else begin
      checkOutput("ibus_idle", ibus_out, 0);
    end
  end

  initial begin
    raddr = 0; waddr = 0; ibus_in = 0; ir = 0; ir_idx = 0;
    fpram_rom = 1; ctx_push = 0; ctx_pop = 0;
    #1 rst = 1;
    #21 rst = 0;

    // Disabled block: panel default on AEXT and on MBn reads.
    applyStimulus(5'b00000, 5'b00100, 16'h0, 3'd0, 0, 0, 0);
    checkOutput("aext_reset", aext, 8'h80);
    checkOutput("war_decode", war, 1'b1);
    applyStimulus(5'b11011, 5'b00000, 16'h0, 3'd0, 0, 0, 0);
    checkOutput("rmbn_disabled", ibus_out, 16'h0080);
    checkOutput("oe_rmbn", ibus_oe, 1'b1);
    checkOutput("en_reset", en, 1'b0);

    // Context 5, bank writes and the first MBn write enabling the unit.
    applyStimulus(5'b00000, 5'b11101, 16'h0005, 3'd0, 0, 0, 0);
    applyStimulus(5'b00000, 5'b11011, 16'h003C, 3'd3, 0, 0, 0);
    applyStimulus(5'b11011, 5'b00000, 16'h0, 3'd3, 0, 0, 0);
    checkOutput("en_after_wmbn", en, 1'b1);
    checkOutput("rmbn_b3", ibus_out, 16'h003C);
    applyStimulus(5'b00000, 5'b00111, 16'h0, 3'd0, 0, 0, 0);
    checkOutput("aext_b3", aext, 8'h3C);
    applyStimulus(5'b00000, 5'b11011, 16'h0011, 3'd1, 0, 0, 0);
    applyStimulus(5'b00000, 5'b11011, 16'h0022, 3'd2, 0, 0, 0);

    // MBp write and IR-indexed AR writes.
    applyStimulus(5'b00000, 5'b11100, 16'h00A1, 3'd0, 0, 0, 0);
    applyStimulus(5'b11100, 5'b00000, 16'h0, 3'd0, 0, 0, 0);
    checkOutput("rmbp", ibus_out, 16'h00A1);
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 1, 0, 0);
    applyStimulus(5'b00000, 5'b00110, 16'h0, 3'd0, 0, 0, 0);
    checkOutput("aext_armed", aext, 8'hA1);
    applyStimulus(5'b00000, 5'b00110, 16'h0, 3'd0, 0, 0, 0);
    checkOutput("aext_disarmed", aext, 8'h22);
    applyStimulus(5'b00000, 5'b00101, 16'h0, 3'd3, 1, 0, 0);
    checkOutput("aext_idx_same_cycle", aext, 8'h11);
    applyStimulus(5'b00000, 5'b00110, 16'h0, 3'd3, 0, 0, 0);
    checkOutput("aext_idx_kept", aext, 8'h3C);

    // Push/pop sequence ending in an underflow.
    applyStimulus(5'b00000, 5'b11101, 16'h0007, 3'd0, 0, 0, 0);
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 1, 0);
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 1, 0);
    readCtx(16'h0000, "ctx_after_push");
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 0, 1);
    readCtx(16'h0000, "ctx_pop1");
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 0, 1);
    readCtx(16'h0007, "ctx_pop2");
    checkOutput("stk_err_clean", stk_err, 1'b0);
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 0, 1);
    readCtx(16'h0007, "ctx_underflow");
    checkOutput("stk_err_underflow", stk_err, 1'b1);

    // Fill the stack, overflow once, then unwind in LIFO order.
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(5'b00000, 5'b11101, 16'(k), 3'd0, 0, 0, 0);
      applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 1, 0);
    end
    applyStimulus(5'b00000, 5'b11101, 16'h0009, 3'd0, 0, 0, 0);
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 1, 0);
    readCtx(16'h0000, "ctx_overflow");
    for (int k = DEPTH; k >= 1; k--) begin
      applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 0, 1);
      readCtx(16'(k), "ctx_unwind");
    end

    // Push beats a same-edge CTX write; push+pop together changes nothing.
    applyStimulus(5'b00000, 5'b11101, 16'h0002, 3'd0, 0, 0, 0);
    applyStimulus(5'b00000, 5'b11101, 16'h0009, 3'd0, 0, 1, 0);
    readCtx(16'h0000, "ctx_push_over_wctx");
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 0, 1);
    readCtx(16'h0002, "ctx_stack_top");
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 1, 1);
    readCtx(16'h0002, "ctx_push_pop");

    // Asynchronous reset mid-cycle; banks survive and reappear after re-enable.
    @(posedge clk);
    #3 rst = 1;
    #1;
    checkOutput("en_async_rst", en, 1'b0);
    checkOutput("stk_err_async_rst", stk_err, 1'b0);
    @(negedge clk);
    #1 rst = 0;
    readCtx(16'h0000, "ctx_after_rst");
    applyStimulus(5'b00000, 5'b00111, 16'h0, 3'd0, 0, 0, 0);
    checkOutput("aext_after_rst", aext, 8'h80);
    applyStimulus(5'b00000, 5'b11101, 16'h0005, 3'd0, 0, 0, 0);
    applyStimulus(5'b00000, 5'b11011, 16'h0055, 3'd0, 0, 0, 0);
    applyStimulus(5'b11011, 5'b00000, 16'h0, 3'd3, 0, 0, 0);
    checkOutput("bank_retained", ibus_out, 16'h003C);
    fpram_rom = 0;
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 0, 0);
    applyStimulus(5'b00000, 5'b00000, 16'h0, 3'd0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
